// File: rtl/prf_wr_arbiter_if.sv
// Write-back request side and bank write-strobe side of the PRF write arbiter.
// The bank strobes also serve as the PR-ready/forward broadcast.
interface prf_wr_arbiter_if #(
   parameter int PRF_WR_COUNT   = 8,
   parameter int PRF_BANK_COUNT = 4,
   parameter int PR_COUNT       = 128,
   parameter int XLEN           = 64
);
   localparam int LOG_PR_COUNT = $clog2(PR_COUNT);
   localparam int BANK_W       = $clog2(PRF_BANK_COUNT);
   localparam int SRC_W        = $clog2(PRF_WR_COUNT);

   logic [PRF_WR_COUNT-1:0]                     wr_valid_by_wr;
   logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]   wr_PR_by_wr;
   logic [PRF_WR_COUNT-1:0][XLEN-1:0]           wr_data_by_wr;
   logic [PRF_WR_COUNT-1:0]                     wr_ready_by_wr;

   logic [PRF_BANK_COUNT-1:0]                          bank_wr_valid_by_bank;
   logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-BANK_W-1:0] bank_wr_upper_PR_by_bank;
   logic [PRF_BANK_COUNT-1:0][XLEN-1:0]                bank_wr_data_by_bank;
   logic [PRF_BANK_COUNT-1:0][SRC_W-1:0]               bank_wr_src_by_bank;

   modport master (
      output wr_valid_by_wr, wr_PR_by_wr, wr_data_by_wr,
      input  wr_ready_by_wr,
      input  bank_wr_valid_by_bank, bank_wr_upper_PR_by_bank,
             bank_wr_data_by_bank, bank_wr_src_by_bank
   );

   modport slave (
      input  wr_valid_by_wr, wr_PR_by_wr, wr_data_by_wr,
      output wr_ready_by_wr,
      output bank_wr_valid_by_bank, bank_wr_upper_PR_by_bank,
             bank_wr_data_by_bank, bank_wr_src_by_bank
   );
endinterface

// File: rtl/prf_wr_arbiter.sv
// Per-requester input FIFOs feeding one round-robin arbiter per PRF bank;
// winners become registered single-port bank write strobes.
module prf_wr_arbiter #(
   parameter int PRF_WR_COUNT             = 8,
   parameter int PRF_BANK_COUNT           = 4,
   parameter int PRF_WR_INPUT_BUFFER_SIZE = 2,
   parameter int PR_COUNT                 = 128,
   parameter int XLEN                     = 64
) (
   input  logic            CLK,
   input  logic            nRST,
   prf_wr_arbiter_if.slave bus_if
);
   localparam int LOG_PR = $clog2(PR_COUNT);
   localparam int BANK_W = $clog2(PRF_BANK_COUNT);
   localparam int ROW_W  = LOG_PR - BANK_W;
   localparam int SRC_W  = $clog2(PRF_WR_COUNT);
   localparam int DEPTH  = PRF_WR_INPUT_BUFFER_SIZE;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W  = $clog2(DEPTH + 1);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [OCC_W-1:0] occ_t;
   typedef logic [SRC_W-1:0] src_t;

   logic [LOG_PR-1:0] fifo_pr_q   [PRF_WR_COUNT][DEPTH];
   logic [XLEN-1:0]   fifo_data_q [PRF_WR_COUNT][DEPTH];

   ptr_t [PRF_WR_COUNT-1:0] head_q, head_d, tail_q, tail_d;
   occ_t [PRF_WR_COUNT-1:0] occ_q, occ_d;
   src_t [PRF_BANK_COUNT-1:0] rr_ptr_q, rr_ptr_d;

   logic [PRF_BANK_COUNT-1:0]            bank_valid_q, bank_valid_d;
   logic [PRF_BANK_COUNT-1:0][ROW_W-1:0] bank_upper_q, bank_upper_d;
   logic [PRF_BANK_COUNT-1:0][XLEN-1:0]  bank_data_q, bank_data_d;
   src_t [PRF_BANK_COUNT-1:0]            bank_src_q, bank_src_d;

   logic [PRF_WR_COUNT-1:0]             ready, enq, deq;
   logic [PRF_WR_COUNT-1:0][LOG_PR-1:0] head_pr;
   logic [PRF_WR_COUNT-1:0][XLEN-1:0]   head_data;
   logic [PRF_BANK_COUNT-1:0]           gnt_valid;
   src_t [PRF_BANK_COUNT-1:0]           gnt_src;

   function automatic ptr_t ptr_inc(ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // Ready looks only at registered occupancy, so a full FIFO refuses even
   // when its head leaves this cycle; this keeps valid->ready acyclic.
   always_comb begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
         ready[i]     = occ_q[i] < occ_t'(DEPTH);
         enq[i]       = bus_if.wr_valid_by_wr[i] & ready[i];
         head_pr[i]   = fifo_pr_q[i][head_q[i]];
         head_data[i] = fifo_data_q[i][head_q[i]];
      end
   end

   always_comb begin
      logic found;
      src_t cand;
      // NOTE: every always_comb output gets a default before any conditional
      // assignment; a missing default on some path infers a latch.
      gnt_valid = '0;
      gnt_src   = '0;
      deq       = '0;
      found     = 1'b0;
      cand      = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         found = 1'b0;
         for (int k = 0; k < PRF_WR_COUNT; k++) begin
            cand = src_t'((int'(rr_ptr_q[b]) + k) % PRF_WR_COUNT);
            if (!found && occ_q[cand] != '0 &&
                head_pr[cand][BANK_W-1:0] == BANK_W'(b)) begin
               found        = 1'b1;
               gnt_valid[b] = 1'b1;
               gnt_src[b]   = cand;
            end
         end
         if (found) deq[gnt_src[b]] = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
         head_d[i] = deq[i] ? ptr_inc(head_q[i]) : head_q[i];
         tail_d[i] = enq[i] ? ptr_inc(tail_q[i]) : tail_q[i];
         occ_d[i]  = occ_q[i];
         if (enq[i] && !deq[i])      occ_d[i] = occ_q[i] + occ_t'(1);
         else if (!enq[i] && deq[i]) occ_d[i] = occ_q[i] - occ_t'(1);
      end
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         bank_valid_d[b] = gnt_valid[b];
         rr_ptr_d[b]     = rr_ptr_q[b];
         bank_upper_d[b] = bank_upper_q[b];
         bank_data_d[b]  = bank_data_q[b];
         bank_src_d[b]   = bank_src_q[b];
         if (gnt_valid[b]) begin
            rr_ptr_d[b]     = (gnt_src[b] == src_t'(PRF_WR_COUNT - 1)) ? '0
                                                                       : gnt_src[b] + src_t'(1);
            bank_upper_d[b] = head_pr[gnt_src[b]][LOG_PR-1:BANK_W];
            bank_data_d[b]  = head_data[gnt_src[b]];
            bank_src_d[b]   = gnt_src[b];
         end
      end
   end

   // NOTE: FIFO storage is deliberately not reset; occupancy gates every read,
   // so stale entries are never observed and the array stays plain RAM.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
         if (enq[i]) begin
            fifo_pr_q[i][tail_q[i]]   <= bus_if.wr_PR_by_wr[i];
            fifo_data_q[i][tail_q[i]] <= bus_if.wr_data_by_wr[i];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the same pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head_q       <= '0;
         tail_q       <= '0;
         occ_q        <= '0;
         rr_ptr_q     <= '0;
         bank_valid_q <= '0;
         bank_upper_q <= '0;
         bank_data_q  <= '0;
         bank_src_q   <= '0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         occ_q        <= occ_d;
         rr_ptr_q     <= rr_ptr_d;
         bank_valid_q <= bank_valid_d;
         bank_upper_q <= bank_upper_d;
         bank_data_q  <= bank_data_d;
         bank_src_q   <= bank_src_d;
      end
   end

   assign bus_if.wr_ready_by_wr           = ready;
   assign bus_if.bank_wr_valid_by_bank    = bank_valid_q;
   assign bus_if.bank_wr_upper_PR_by_bank = bank_upper_q;
   assign bus_if.bank_wr_data_by_bank     = bank_data_q;
   assign bus_if.bank_wr_src_by_bank      = bank_src_q;
endmodule
